// File: rtl/gcd_arb_pkg.sv
// gcd_arb_pkg: shared widths, message types and the round-robin pick helper
// used by the GCD arbiter, its tag FIFO and its interface.
package gcd_arb_pkg;

    localparam int GCD_OPW  = 16;
    localparam int GCD_REQW = 32;

    typedef logic [GCD_REQW-1:0] gcd_req_t;   // {b[31:16], a[15:0]}
    typedef logic [GCD_OPW-1:0]  gcd_resp_t;  // GCD result

    // Returns the first set bit of req scanning ptr, ptr+1, ... modulo n.
    // When nothing is requested the pointer itself is returned.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && req[idx]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// gcd_arbiter_if: client-side and GcdUnit-side valid/ready buses of the arbiter.
//   cli_req_*  : per-client requests (message slice i = bits [32i+31:32i])
//   cli_resp_* : per-client responses, result broadcast on cli_resp_msg
//   gcd_req_*  : forwarded request to the shared GcdUnit
//   gcd_resp_* : response from the shared GcdUnit
// slave  = the arbiter itself; master = its environment (clients + GcdUnit).
interface gcd_arbiter_if #(
    parameter int NUM_CLIENTS = 4
);
    import gcd_arb_pkg::*;

    logic [NUM_CLIENTS-1:0]          cli_req_val;
    logic [NUM_CLIENTS-1:0]          cli_req_rdy;
    logic [NUM_CLIENTS*GCD_REQW-1:0] cli_req_msg;
    logic [NUM_CLIENTS-1:0]          cli_resp_val;
    logic [NUM_CLIENTS-1:0]          cli_resp_rdy;
    gcd_resp_t                       cli_resp_msg;

    logic      gcd_req_val;
    logic      gcd_req_rdy;
    gcd_req_t  gcd_req_msg;
    logic      gcd_resp_val;
    logic      gcd_resp_rdy;
    gcd_resp_t gcd_resp_msg;

    modport slave (
        input  cli_req_val, cli_req_msg, cli_resp_rdy,
        input  gcd_req_rdy, gcd_resp_val, gcd_resp_msg,
        output cli_req_rdy, cli_resp_val, cli_resp_msg,
        output gcd_req_val, gcd_req_msg, gcd_resp_rdy
    );

    modport master (
        output cli_req_val, cli_req_msg, cli_resp_rdy,
        output gcd_req_rdy, gcd_resp_val, gcd_resp_msg,
        input  cli_req_rdy, cli_resp_val, cli_resp_msg,
        input  gcd_req_val, gcd_req_msg, gcd_resp_rdy
    );

endinterface

// File: rtl/gcd_tag_fifo.sv
// gcd_tag_fifo: in-order FIFO of requester IDs for in-flight GCD requests.
//   push/push_tag : enqueue a tag (ignored when full)
//   pop           : dequeue the head tag (ignored when empty)
//   full/empty    : occupancy flags derived from the registered count
//   count         : current occupancy, 0..DEPTH
//   head          : tag at the FIFO head
module gcd_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_tag,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two; the count,
    // not the pointers, tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: tag storage has no reset; an entry is only read after it was
    // written, since count gates every use of head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_tag;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one GcdUnit between NUM_CLIENTS requesters.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : client and GcdUnit valid/ready buses (slave side)
//   outstanding  : number of in-flight requests (tag FIFO occupancy)
//   err_orphan   : sticky, set when the GcdUnit responds with nothing in flight
// Requests are granted round-robin and forwarded combinationally; the granted
// ID is queued so each response is steered back to its requester in order.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NUM_CLIENTS     = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    gcd_arbiter_if.slave                     bus,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             err_orphan
);
    localparam int IDW = $clog2(NUM_CLIENTS);

    logic [IDW-1:0] rr_ptr_q,  rr_ptr_d;
    logic           lock_vld_q, lock_vld_d;
    logic [IDW-1:0] lock_id_q,  lock_id_d;
    logic           err_orphan_q, err_orphan_d;

    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] head_id;
    logic           full, empty;
    logic           req_fire, resp_fire;

    // A stalled grant stays locked so a newly arriving higher-priority client
    // cannot swap the message under a pending GcdUnit request.
    assign grant_id = lock_vld_q
                    ? lock_id_q
                    : IDW'(rr_pick(16'(bus.cli_req_val), 4'(rr_ptr_q), NUM_CLIENTS));

    assign bus.gcd_req_val  = (|bus.cli_req_val) && !full;
    assign bus.gcd_req_msg  = bus.cli_req_msg[grant_id*GCD_REQW +: GCD_REQW];
    assign req_fire         = bus.gcd_req_val && bus.gcd_req_rdy;

    assign bus.gcd_resp_rdy = !empty && bus.cli_resp_rdy[head_id];
    assign bus.cli_resp_msg = bus.gcd_resp_msg;
    assign resp_fire        = bus.gcd_resp_val && bus.gcd_resp_rdy;

    assign err_orphan       = err_orphan_q;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        bus.cli_req_rdy  = '0;
        bus.cli_resp_val = '0;
        rr_ptr_d         = rr_ptr_q;
        lock_vld_d       = lock_vld_q;
        lock_id_d        = lock_id_q;
        err_orphan_d     = err_orphan_q || (bus.gcd_resp_val && empty);

        bus.cli_req_rdy[grant_id] = bus.gcd_req_rdy && !full;
        bus.cli_resp_val[head_id] = bus.gcd_resp_val && !empty;

        if (req_fire) begin
            rr_ptr_d   = IDW'((int'(grant_id) + 1) % NUM_CLIENTS);
            lock_vld_d = 1'b0;
        end else if (bus.gcd_req_val) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= '0;
            lock_vld_q   <= 1'b0;
            lock_id_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    gcd_tag_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (req_fire),
        .push_tag (grant_id),
        .pop      (resp_fire),
        .full     (full),
        .empty    (empty),
        .count    (outstanding),
        .head     (head_id)
    );

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed scenarios plus a randomized run for gcd_arbiter.
// The bench plays the clients and the GcdUnit; expected values come from a
// transaction-level model (pending requests, a round-robin pointer and an
// in-order queue of forwarded requests).
module tb_gcd_arbiter;
    import gcd_arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] outstanding;
    logic       err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    gcd_arbiter_if #(.NUM_CLIENTS(N)) bus ();

    gcd_arbiter #(
        .NUM_CLIENTS     (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .outstanding (outstanding),
        .err_orphan  (err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int a;
        int b;
    } ent_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cli_req_val  = '0;
        bus.cli_req_msg  = '0;
        bus.cli_resp_rdy = '0;
        bus.gcd_req_rdy  = 1'b0;
        bus.gcd_resp_val = 1'b0;
        bus.gcd_resp_msg = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.cli_req_val[i] = 1'b1;
        bus.cli_req_msg[i*32 +: 32] = {b, a};
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Model state for the randomized run.
    int          m_ptr, m_lock, m_lock_id;
    bit          pend [N];
    logic [15:0] pa [N];
    logic [15:0] pb [N];
    ent_t        mq [$];

    initial begin
        int a_t [4];
        int b_t [4];
        int r_t [4];
        logic [15:0] ga, gb;

        a_t = '{27, 7, 100, 0};
        b_t = '{36, 13, 75, 5};
        r_t = '{9, 1, 25, 5};

        // ---------------- reset state
        do_reset();
        check("rst_outstanding", outstanding, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_gcd_req_val", bus.gcd_req_val, 0);
        check("rst_gcd_resp_rdy", bus.gcd_resp_rdy, 0);
        check("rst_cli_req_rdy", bus.cli_req_rdy, 0);
        check("rst_cli_resp_val", bus.cli_resp_val, 0);
        bus.gcd_resp_msg = 16'h1234;
        #1;
        check("rst_resp_msg_follow", bus.cli_resp_msg, 16'h1234);
        bus.gcd_resp_msg = '0;

        // ---------------- single client
        set_req(2, 16'd12, 16'd18);
        bus.gcd_req_rdy = 1'b1;
        bus.cli_resp_rdy = '1;
        #1;
        check("single_req_val", bus.gcd_req_val, 1);
        check("single_req_msg", bus.gcd_req_msg, 32'h0012000C);
        check("single_req_rdy", bus.cli_req_rdy, 4'b0100);
        tick();
        bus.cli_req_val = '0;
        bus.gcd_resp_val = 1'b1;
        bus.gcd_resp_msg = 16'(ref_gcd(12, 18));
        #1;
        check("single_outst_1", outstanding, 1);
        check("single_resp_val", bus.cli_resp_val, 4'b0100);
        check("single_resp_msg", bus.cli_resp_msg, 6);
        check("single_gcd_resp_rdy", bus.gcd_resp_rdy, 1);
        tick();
        bus.gcd_resp_val = 1'b0;
        #1;
        check("single_outst_0", outstanding, 0);

        // ---------------- all four clients together
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 16'(a_t[k]), 16'(b_t[k]));
        bus.gcd_req_rdy = 1'b1;
        bus.cli_resp_rdy = '1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("all4_grant", bus.cli_req_rdy, onehot(k));
            check("all4_msg", bus.gcd_req_msg, {16'(b_t[k]), 16'(a_t[k])});
            tick();
            bus.cli_req_val[k] = 1'b0;
        end
        #1;
        check("all4_outst_full", outstanding, 4);
        for (int k = 0; k < 4; k++) begin
            bus.gcd_resp_val = 1'b1;
            bus.gcd_resp_msg = 16'(ref_gcd(a_t[k], b_t[k]));
            #1;
            check("all4_resp_route", bus.cli_resp_val, onehot(k));
            check("all4_resp_msg", bus.cli_resp_msg, 32'(r_t[k]));
            tick();
        end
        bus.gcd_resp_val = 1'b0;
        #1;
        check("all4_outst_drained", outstanding, 0);

        // ---------------- grant lock
        do_reset();
        set_req(3, 16'd40, 16'd60);
        bus.gcd_req_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_req(0, 16'd9, 16'd6);
            #1;
            check("lock_msg_stable", bus.gcd_req_msg, {16'd60, 16'd40});
            check("lock_no_rdy", bus.cli_req_rdy, 0);
            tick();
        end
        bus.gcd_req_rdy = 1'b1;
        #1;
        check("lock_first_grant", bus.cli_req_rdy, 4'b1000);
        tick();
        bus.cli_req_val[3] = 1'b0;
        #1;
        check("lock_second_grant", bus.cli_req_rdy, 4'b0001);
        check("lock_second_msg", bus.gcd_req_msg, {16'd6, 16'd9});
        tick();
        bus.cli_req_val[0] = 1'b0;
        bus.cli_resp_rdy = '1;
        bus.gcd_resp_val = 1'b1;
        bus.gcd_resp_msg = 16'(ref_gcd(40, 60));
        #1;
        check("lock_outst", outstanding, 2);
        check("lock_resp0_route", bus.cli_resp_val, 4'b1000);
        tick();
        bus.gcd_resp_msg = 16'(ref_gcd(9, 6));
        #1;
        check("lock_resp1_route", bus.cli_resp_val, 4'b0001);
        tick();
        bus.gcd_resp_val = 1'b0;

        // ---------------- full FIFO
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 16'(k + 2), 16'(k + 4));
        bus.gcd_req_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.cli_req_val[k] = 1'b0;
        end
        set_req(1, 16'd21, 16'd14);
        #1;
        check("full_outst", outstanding, 4);
        check("full_no_rdy", bus.cli_req_rdy, 0);
        check("full_no_val", bus.gcd_req_val, 0);
        bus.cli_resp_rdy = '1;
        bus.gcd_resp_val = 1'b1;
        bus.gcd_resp_msg = 16'(ref_gcd(2, 4));
        #1;
        check("full_pop_fires", bus.gcd_resp_rdy, 1);
        check("full_pop_still_blocked", bus.cli_req_rdy, 0);
        tick();
        bus.gcd_resp_val = 1'b0;
        #1;
        check("full_after_pop_outst", outstanding, 3);
        check("full_fifth_accepted", bus.cli_req_rdy, 4'b0010);
        tick();
        bus.cli_req_val = '0;
        #1;
        check("full_refilled", outstanding, 4);

        // ---------------- response backpressure
        do_reset();
        set_req(1, 16'd8, 16'd12);
        bus.gcd_req_rdy = 1'b1;
        tick();
        bus.cli_req_val = '0;
        bus.gcd_resp_val = 1'b1;
        bus.gcd_resp_msg = 16'(ref_gcd(8, 12));
        bus.cli_resp_rdy = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_resp_rdy_low", bus.gcd_resp_rdy, 0);
            check("bp_resp_val", bus.cli_resp_val, 4'b0010);
            check("bp_no_pop", outstanding, 1);
            tick();
        end
        bus.cli_resp_rdy[1] = 1'b1;
        #1;
        check("bp_resp_rdy_high", bus.gcd_resp_rdy, 1);
        check("bp_resp_msg", bus.cli_resp_msg, 4);
        tick();
        bus.gcd_resp_val = 1'b0;
        #1;
        check("bp_popped", outstanding, 0);

        // ---------------- orphan response and mid-flight reset
        do_reset();
        bus.cli_resp_rdy = '1;
        bus.gcd_resp_val = 1'b1;
        #1;
        check("orphan_resp_rdy", bus.gcd_resp_rdy, 0);
        check("orphan_no_route", bus.cli_resp_val, 0);
        tick();
        bus.gcd_resp_val = 1'b0;
        #1;
        check("orphan_set", err_orphan, 1);
        tick();
        tick();
        check("orphan_sticky", err_orphan, 1);
        for (int k = 0; k < 3; k++) set_req(k, 16'd3, 16'd9);
        bus.gcd_req_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.cli_req_val[k] = 1'b0;
        end
        #1;
        check("midrst_outst_3", outstanding, 3);
        reset_n = 1'b0;
        #1;
        check("midrst_outst_0", outstanding, 0);
        check("midrst_err_clear", err_orphan, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) set_req(k, 16'd5, 16'd10);
        bus.gcd_req_rdy = 1'b1;
        #1;
        check("midrst_ptr_zero", bus.cli_req_rdy, 4'b0001);

        // ---------------- randomized run against the transaction model
        do_reset();
        m_ptr = 0;
        m_lock = 0;
        m_lock_id = 0;
        mq.delete();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pa[i] = '0;
            pb[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int          g;
            bit          any, full, exp_val, exp_rrdy, req_fire, resp_fire;
            logic [N-1:0] exp_rdy, exp_rval;

            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 35) begin
                    pend[i] = 1'b1;
                    pa[i] = 16'($urandom_range(0, 255));
                    pb[i] = 16'($urandom_range(1, 255));
                end
                bus.cli_req_val[i] = pend[i];
                bus.cli_req_msg[i*32 +: 32] = {pb[i], pa[i]};
            end
            bus.gcd_req_rdy  = ($urandom_range(0, 99) < 60);
            bus.cli_resp_rdy = N'($urandom_range(0, 15));
            if (mq.size() > 0 && $urandom_range(0, 99) < 60) begin
                bus.gcd_resp_val = 1'b1;
                bus.gcd_resp_msg = 16'(ref_gcd(mq[0].a, mq[0].b));
            end else begin
                bus.gcd_resp_val = 1'b0;
                bus.gcd_resp_msg = 16'($urandom_range(0, 65535));
            end
            #1;

            any  = 1'b0;
            for (int i = 0; i < N; i++) any |= pend[i];
            full = (mq.size() == MAXO);
            if (m_lock != 0) begin
                g = m_lock_id;
            end else begin
                g = m_ptr;
                for (int k = N - 1; k >= 0; k--)
                    if (pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            exp_val  = any && !full;
            exp_rdy  = (bus.gcd_req_rdy && !full) ? onehot(g) : '0;
            exp_rval = (bus.gcd_resp_val && mq.size() > 0) ? onehot(mq[0].id) : '0;
            exp_rrdy = (mq.size() > 0) ? bus.cli_resp_rdy[mq[0].id] : 1'b0;

            check("rnd_gcd_req_val", bus.gcd_req_val, exp_val);
            check("rnd_cli_req_rdy", bus.cli_req_rdy, exp_rdy);
            if (exp_val) check("rnd_gcd_req_msg", bus.gcd_req_msg, {pb[g], pa[g]});
            check("rnd_cli_resp_val", bus.cli_resp_val, exp_rval);
            check("rnd_gcd_resp_rdy", bus.gcd_resp_rdy, exp_rrdy);
            check("rnd_cli_resp_msg", bus.cli_resp_msg, bus.gcd_resp_msg);
            check("rnd_outstanding", outstanding, mq.size());

            req_fire  = exp_val && bus.gcd_req_rdy;
            resp_fire = exp_rrdy && bus.gcd_resp_val;
            tick();
            if (resp_fire) void'(mq.pop_front());
            if (req_fire) begin
                mq.push_back('{id: g, a: int'(pa[g]), b: int'(pb[g])});
                pend[g] = 1'b0;
                m_ptr   = (g + 1) % N;
                m_lock  = 0;
            end else if (exp_val) begin
                m_lock    = 1;
                m_lock_id = g;
            end
        end
        check("rnd_no_orphan", err_orphan, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net: the directed sequence is bounded, but never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
